mux_stream_rr: RTL

//  Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes and a

---
 rtl/mux_pkg.sv | 5 +
 rtl/mux_rr_pick.sv | 22 ++
 rtl/mux_stream_rr.sv | 84 ++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode and output-stage state types for mux_stream_rr
package mux_pkg;
  typedef enum logic {MUX_FIXED = 1'b0, MUX_RR = 1'b1} mux_mode_e;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} mux_state_e;
endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick: first valid channel at or after ptr, wrapping, via rotate then priority encode
module mux_rr_pick #(
  parameter int N = 3,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);
  logic [N-1:0] rot;
  logic [SELW-1:0] off;
  int sum;
  assign rot = N'({valid, valid} >> ptr);
  always_comb begin
    found = |rot;
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? SELW'(k) : off;
    sum = int'(ptr) + int'(off);
    idx = sum >= N ? SELW'(sum - N) : SELW'(sum);
  end
endmodule

// File: rtl/mux_stream_rr.sv
// mux_stream_rr: N-channel stream mux, fixed or round-robin select, registered output stage
// Define MUX_STATS_EN to add saturating per-channel grant counters on grant_cnt.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 3,
  parameter int CNT_W = 16,
  localparam int SELW = $clog2(N) > 1 ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   grant,
  output logic              err_sel
`ifdef MUX_STATS_EN
  ,
  output logic [N*CNT_W-1:0] grant_cnt
`endif
);
  mux_mode_e mode_e;
  mux_state_e state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic [SELW-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx, cand;
  logic err_q, err_d, pick_found, sel_ok, cand_ok, load_en, xfer;
  assign mode_e = mux_mode_e'(mode);
  mux_rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .valid(in_valid),
    .ptr(ptr_q),
    .found(pick_found),
    .idx(pick_idx)
  );
  always_comb begin
    sel_ok = int'(sel) < N;
    cand = mode_e == MUX_RR ? pick_idx : sel;
    cand_ok = mode_e == MUX_RR ? pick_found : sel_ok;
    load_en = state_q == ST_EMPTY || out_ready;
    xfer = load_en && cand_ok && in_valid[cand];
    in_ready = xfer ? N'(1) << cand : '0;
    state_d = xfer ? ST_FULL : out_ready ? ST_EMPTY : state_q;
    data_d = xfer ? in_data[cand*W +: W] : data_q;
    grant_d = xfer ? cand : grant_q;
    ptr_d = xfer && mode_e == MUX_RR ? (int'(cand) == N - 1 ? '0 : cand + 1'b1) : ptr_q;
    err_d = mode_e == MUX_FIXED && !sel_ok;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q <= '0;
      grant_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end
  assign out_valid = state_q == ST_FULL;
  assign out_data = data_q;
  assign grant = grant_q;
  assign err_sel = err_q;
`ifdef MUX_STATS_EN
  logic [N*CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !(&cnt_q[cand*CNT_W +: CNT_W])) cnt_d[cand*CNT_W +: CNT_W] = cnt_q[cand*CNT_W +: CNT_W] + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign grant_cnt = cnt_q;
`endif
endmodule
